// File: rtl/e_s_pkg.sv
// Shared constants and helpers for the handshaked CPU I/O block.
package e_s_pkg;

    localparam logic SRC_MEM = 1'b0;
    localparam logic SRC_REG = 1'b1;

    // Bit offset of channel k inside a packed NCH*width bus.
    function automatic int unsigned chan_slice(input int unsigned k, input int unsigned width);
        return k * width;
    endfunction

endpackage

// File: rtl/e_s_canal_in.sv
// One input channel: strobe-captured latch with full and sticky overrun flags.
module e_s_canal_in #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stb,
    input  logic [WIDTH-1:0] din,
    input  logic             consume,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             ovf
);

    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= '0;
            full <= 1'b0;
            ovf  <= 1'b0;
        end else if (stb && (!full || consume)) begin
            // A read in the same cycle frees the slot, so the new sample is taken without overrun.
            dout <= din;
            full <= 1'b1;
            ovf  <= 1'b0;
        end else if (stb) begin
            ovf <= 1'b1;
        end else if (consume) begin
            full <= 1'b0;
            ovf  <= 1'b0;
        end
    end

endmodule

// File: rtl/e_s_hs.sv
// CPU I/O block: NCH strobe-captured input channels and NCH handshaked output channels.
module e_s_hs
    import e_s_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NCH    = 4,
    parameter int unsigned IDW    = $clog2(NCH),
    parameter int unsigned OUT_HS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sec,
    input  logic                 we,
    input  logic [IDW-1:0]       id_out,
    input  logic                 rd,
    input  logic [IDW-1:0]       id_in,
    input  logic [WIDTH-1:0]     data_mem,
    input  logic [WIDTH-1:0]     data_reg,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_stb,
    input  logic [NCH-1:0]       out_ack,
    output logic [WIDTH-1:0]     data_in,
    output logic [NCH-1:0]       in_full,
    output logic [NCH-1:0]       in_ovf,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]       out_valid
);

    logic [WIDTH-1:0] lat    [NCH];
    logic [WIDTH-1:0] hold_q [NCH];
    logic             vld_q  [NCH];
    logic [WIDTH-1:0] src;

    assign src     = (sec == SRC_REG) ? data_reg : data_mem;
    assign data_in = lat[id_in];

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        localparam int unsigned    OFS = chan_slice(k, WIDTH);
        localparam logic [IDW-1:0] KID = IDW'(k);

        e_s_canal_in #(
            .WIDTH(WIDTH)
        ) u_in (
            .clk    (clk),
            .reset  (reset),
            .stb    (in_stb[k]),
            .din    (in_data[OFS +: WIDTH]),
            .consume(rd && (id_in == KID)),
            .dout   (lat[k]),
            .full   (in_full[k]),
            .ovf    (in_ovf[k])
        );

        // A CPU write beats a same-cycle ack so fresh data is never dropped.
        always_ff @(posedge clk) begin
            if (reset) begin
                hold_q[k] <= '0;
                vld_q[k]  <= 1'b0;
            end else if (we && (id_out == KID)) begin
                hold_q[k] <= src;
                vld_q[k]  <= 1'b1;
            end else if (OUT_HS == 0) begin
                vld_q[k] <= 1'b0;
            end else if (out_ack[k]) begin
                vld_q[k] <= 1'b0;
            end
        end

        assign out_data[OFS +: WIDTH] = hold_q[k];
        assign out_valid[k]           = vld_q[k];
    end

endmodule

// File: tb/tb_e_s_hs.sv
// Scoreboard bench: two builds (8x4 handshaked, 16x8 pulsed) checked against a channel-rule model.
module tb_e_s_hs;

    typedef struct packed {
        logic         reset;
        logic         sec;
        logic         we;
        logic         rd;
        logic [3:0]   id_out;
        logic [3:0]   id_in;
        logic [15:0]  dmem;
        logic [15:0]  dreg;
        logic [255:0] din;
        logic [15:0]  stb;
        logic [15:0]  ack;
    } stim_t;

    typedef struct packed {
        logic [15:0]  data_in;
        logic [15:0]  full;
        logic [15:0]  ovf;
        logic [15:0]  valid;
        logic [255:0] od;
    } snap_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_sec, a_we, a_rd;
    logic [1:0]  a_id_out, a_id_in;
    logic [7:0]  a_dmem, a_dreg, a_data_in;
    logic [31:0] a_in_data, a_out_data;
    logic [3:0]  a_stb, a_ack, a_full, a_ovf, a_valid;

    logic         b_reset, b_sec, b_we, b_rd;
    logic [2:0]   b_id_out, b_id_in;
    logic [15:0]  b_dmem, b_dreg, b_data_in;
    logic [127:0] b_in_data, b_out_data;
    logic [7:0]   b_stb, b_ack, b_full, b_ovf, b_valid;

    e_s_hs #(.WIDTH(8), .NCH(4), .OUT_HS(1)) u_dut_a (
        .clk(clk), .reset(a_reset), .sec(a_sec), .we(a_we), .id_out(a_id_out),
        .rd(a_rd), .id_in(a_id_in), .data_mem(a_dmem), .data_reg(a_dreg),
        .in_data(a_in_data), .in_stb(a_stb), .out_ack(a_ack), .data_in(a_data_in),
        .in_full(a_full), .in_ovf(a_ovf), .out_data(a_out_data), .out_valid(a_valid)
    );

    e_s_hs #(.WIDTH(16), .NCH(8), .OUT_HS(0)) u_dut_b (
        .clk(clk), .reset(b_reset), .sec(b_sec), .we(b_we), .id_out(b_id_out),
        .rd(b_rd), .id_in(b_id_in), .data_mem(b_dmem), .data_reg(b_dreg),
        .in_data(b_in_data), .in_stb(b_stb), .out_ack(b_ack), .data_in(b_data_in),
        .in_full(b_full), .in_ovf(b_ovf), .out_data(b_out_data), .out_valid(b_valid)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;

    stim_t st [2];
    snap_t q0 [$];
    snap_t q1 [$];

    logic [15:0] m_lat [2][16];
    logic [15:0] m_od  [2][16];
    logic        m_full[2][16];
    logic        m_ovf [2][16];
    logic        m_vld [2][16];
    bit          m_ok  [2];

    function automatic int unsigned nch(input int d);
        return (d == 0) ? 4 : 8;
    endfunction

    function automatic logic [15:0] msk(input int d);
        return (d == 0) ? 16'h00ff : 16'hffff;
    endfunction

    task automatic drive(input int d);
        if (d == 0) begin
            a_reset = st[0].reset; a_sec = st[0].sec; a_we = st[0].we; a_rd = st[0].rd;
            a_id_out = st[0].id_out[1:0]; a_id_in = st[0].id_in[1:0];
            a_dmem = st[0].dmem[7:0]; a_dreg = st[0].dreg[7:0];
            a_stb = st[0].stb[3:0]; a_ack = st[0].ack[3:0];
            for (int k = 0; k < 4; k++) a_in_data[k*8 +: 8] = st[0].din[k*16 +: 8];
        end else begin
            b_reset = st[1].reset; b_sec = st[1].sec; b_we = st[1].we; b_rd = st[1].rd;
            b_id_out = st[1].id_out[2:0]; b_id_in = st[1].id_in[2:0];
            b_dmem = st[1].dmem; b_dreg = st[1].dreg;
            b_stb = st[1].stb[7:0]; b_ack = st[1].ack[7:0];
            for (int k = 0; k < 8; k++) b_in_data[k*16 +: 16] = st[1].din[k*16 +: 16];
        end
    endtask

    task automatic push_expected(input int d);
        snap_t s;
        int unsigned n;
        if (!m_ok[d]) return;
        n = nch(d);
        s = '0;
        s.data_in = m_lat[d][st[d].id_in % n];
        for (int unsigned k = 0; k < n; k++) begin
            s.full[k]        = m_full[d][k];
            s.ovf[k]         = m_ovf[d][k];
            s.valid[k]       = m_vld[d][k];
            s.od[k*16 +: 16] = m_od[d][k];
        end
        if (d == 0) q0.push_back(s);
        else        q1.push_back(s);
    endtask

    task automatic update(input int d);
        int unsigned n;
        logic [15:0] m;
        bit cons, wr;
        n = nch(d);
        m = msk(d);
        for (int unsigned k = 0; k < n; k++) begin
            cons = st[d].rd && ((st[d].id_in % n) == k);
            wr   = st[d].we && ((st[d].id_out % n) == k);
            if (st[d].reset) begin
                m_lat[d][k] = '0; m_full[d][k] = 0; m_ovf[d][k] = 0;
                m_od[d][k] = '0; m_vld[d][k] = 0;
            end else begin
                if (st[d].stb[k]) begin
                    if (!m_full[d][k] || cons) begin
                        m_lat[d][k] = st[d].din[k*16 +: 16] & m;
                        m_full[d][k] = 1; m_ovf[d][k] = 0;
                    end else begin
                        m_ovf[d][k] = 1;
                    end
                end else if (cons) begin
                    m_full[d][k] = 0; m_ovf[d][k] = 0;
                end
                if (wr) begin
                    m_od[d][k]  = (st[d].sec ? st[d].dreg : st[d].dmem) & m;
                    m_vld[d][k] = 1;
                end else if (d == 1) begin
                    m_vld[d][k] = 0;
                end else if (st[d].ack[k]) begin
                    m_vld[d][k] = 0;
                end
            end
        end
        if (st[d].reset) m_ok[d] = 1;
    endtask

    task automatic cycle();
        for (int d = 0; d < 2; d++) begin
            drive(d);
            push_expected(d);
            update(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        st[0] = '0;
        st[1] = '0;
    endtask

    task automatic randomize_stim(input int d);
        st[d] = '0;
        st[d].reset  = ($urandom_range(0, 63) == 0);
        st[d].sec    = 1'($urandom);
        st[d].we     = ($urandom_range(0, 2) == 0);
        st[d].rd     = ($urandom_range(0, 2) == 0);
        st[d].id_out = 4'($urandom);
        st[d].id_in  = 4'($urandom);
        st[d].dmem   = 16'($urandom);
        st[d].dreg   = 16'($urandom);
        st[d].stb    = 16'($urandom) & 16'($urandom);
        st[d].ack    = 16'($urandom);
        for (int i = 0; i < 8; i++) st[d].din[i*32 +: 32] = $urandom;
    endtask

    function automatic snap_t actual(input int d);
        snap_t s;
        s = '0;
        if (d == 0) begin
            s.data_in = {8'h00, a_data_in};
            s.full = {12'h000, a_full}; s.ovf = {12'h000, a_ovf}; s.valid = {12'h000, a_valid};
            for (int k = 0; k < 4; k++) s.od[k*16 +: 16] = {8'h00, a_out_data[k*8 +: 8]};
        end else begin
            s.data_in = b_data_in;
            s.full = {8'h00, b_full}; s.ovf = {8'h00, b_ovf}; s.valid = {8'h00, b_valid};
            for (int k = 0; k < 8; k++) s.od[k*16 +: 16] = b_out_data[k*16 +: 16];
        end
        return s;
    endfunction

    task automatic cmp(input string name, input int d, input logic [255:0] got, input logic [255:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s dut%0d t=%0t: got %h want %h", name, d, $time, got, want);
        end
    endtask

    // Monitor: one expected snapshot per cycle per build, compared mid-cycle.
    initial begin
        snap_t e, a;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if ((d == 0 && q0.size() != 0) || (d == 1 && q1.size() != 0)) begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    a = actual(d);
                    cmp("data_in",   d, 256'(a.data_in), 256'(e.data_in));
                    cmp("in_full",   d, 256'(a.full),    256'(e.full));
                    cmp("in_ovf",    d, 256'(a.ovf),     256'(e.ovf));
                    cmp("out_valid", d, 256'(a.valid),   256'(e.valid));
                    cmp("out_data",  d, a.od,            e.od);
                end
            end
        end
    end

    initial begin
        idle();
        // Reset held two cycles while every strobe fires.
        for (int i = 0; i < 2; i++) begin
            for (int d = 0; d < 2; d++) begin
                st[d].reset = 1; st[d].stb = 16'hffff;
                for (int j = 0; j < 8; j++) st[d].din[j*32 +: 32] = $urandom;
            end
            cycle();
        end
        idle(); cycle();

        // Capture and read on channel 2.
        idle(); st[0].stb[2] = 1; st[0].din[2*16 +: 16] = 16'h00a5; st[0].id_in = 2; cycle();
        idle(); st[0].id_in = 2; cycle();
        idle(); st[0].id_in = 2; st[0].rd = 1; cycle();
        idle(); st[0].id_in = 2; cycle();
        idle(); st[0].id_in = 2; st[0].rd = 1; cycle();

        // Overrun on channel 1, then read with simultaneous strobe.
        idle(); st[0].stb[1] = 1; st[0].din[1*16 +: 16] = 16'h0011; cycle();
        idle(); st[0].stb[1] = 1; st[0].din[1*16 +: 16] = 16'h0022; cycle();
        idle(); st[0].id_in = 1; cycle();
        idle(); st[0].id_in = 1; st[0].rd = 1; st[0].stb[1] = 1; st[0].din[1*16 +: 16] = 16'h0033; cycle();
        idle(); st[0].id_in = 1; cycle();

        // Output handshake on channel 3.
        idle(); st[0].we = 1; st[0].id_out = 3; st[0].sec = 1; st[0].dreg = 16'h005c; cycle();
        idle(); cycle(); cycle();
        idle(); st[0].ack[3] = 1; cycle();
        idle(); st[0].ack[3] = 1; cycle();
        idle(); st[0].we = 1; st[0].id_out = 3; st[0].sec = 1; st[0].dreg = 16'h005c; cycle();
        idle(); st[0].we = 1; st[0].id_out = 3; st[0].sec = 1; st[0].dreg = 16'h0077; st[0].ack[3] = 1; cycle();
        idle(); cycle();

        // Source select from memory into channel 0.
        idle(); st[0].we = 1; st[0].id_out = 0; st[0].sec = 0; st[0].dmem = 16'h00f0; st[0].dreg = 16'h00aa; cycle();
        idle(); cycle();

        // Reset in the middle of a pending handshake.
        idle(); st[0].we = 1; st[0].id_out = 2; st[0].dreg = 16'h0099; st[0].sec = 1; cycle();
        idle(); st[0].reset = 1; st[0].we = 1; st[0].id_out = 1; st[0].stb = 16'hffff; cycle();
        idle(); cycle();

        // Pulse-mode build: single write, ack ignored; capture/read on channel 7.
        idle(); st[1].we = 1; st[1].id_out = 5; st[1].dmem = 16'h1234; cycle();
        idle(); st[1].ack = 16'hffff; cycle();
        idle(); st[1].ack = 16'hffff; cycle();
        idle(); st[1].stb[7] = 1; st[1].din[7*16 +: 16] = 16'hbeef; st[1].id_in = 7; cycle();
        idle(); st[1].id_in = 7; cycle();
        idle(); st[1].id_in = 7; st[1].rd = 1; cycle();
        idle(); st[1].id_in = 7; cycle();

        for (int i = 0; i < 600; i++) begin
            randomize_stim(0);
            randomize_stim(1);
            cycle();
        end

        idle(); cycle(); cycle();
        tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending want 0/0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/e_s_hs.md
Name: e_s_hs

Overview:
- Parametrised, handshaked successor of the CPU I/O block.
- Serves NCH input and NCH output channels of WIDTH bits.
- Input side: peripheral-strobed capture latches with ready and overrun flags, cleared by CPU reads.
- Output side: per-channel holding registers written from memory or register data, with a valid/ack handshake toward the peripheral.
- Sits between the CPU datapath (data_mem, data_reg, data_in) and the external pins.

Parameters:
- WIDTH, 8: data width of every channel.
- NCH, 4: number of input and of output channels; power of two, 2..16.
- IDW, $clog2(NCH): width of the channel-id fields.
- OUT_HS, 1: 1 = valid held until out_ack; 0 = out_valid is a one-cycle pulse and out_ack is ignored.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sec  in  1  output source select: 0 = data_mem, 1 = data_reg.
- we  in  1  CPU write strobe for output channel id_out.
- id_out  in  IDW  output channel addressed by we.
- rd  in  1  CPU read strobe (consume) for input channel id_in.
- id_in  in  IDW  input channel driving data_in.
- data_mem  in  WIDTH  write data from memory.
- data_reg  in  WIDTH  write data from the register file.
- in_data  in  NCH*WIDTH  packed peripheral input data; channel k at bits [k*WIDTH +: WIDTH].
- in_stb  in  NCH  per-channel capture strobe.
- out_ack  in  NCH  per-channel peripheral acknowledge.
- data_in  out  WIDTH  latched data of channel id_in (combinational mux).
- in_full  out  NCH  channel holds unread data.
- in_ovf  out  NCH  sticky flag: strobe arrived while the channel was full.
- out_data  out  NCH*WIDTH  packed output holding registers.
- out_valid  out  NCH  output data pending for the peripheral.

Behaviour:
- Reset (synchronous, active-high):
  - All latches, out_data, in_full, in_ovf and out_valid go to 0.
  - Reset wins over every same-cycle strobe.
  - Reset mid-handshake drops pending data silently.
- Input channel k, evaluated at the clock edge:
  - in_stb=1 and in_full=0: capture in_data[k]; set in_full next cycle (1-cycle latency).
  - in_stb=1, in_full=1, no consuming read: latch keeps its old data; in_ovf set.
  - Consuming read (rd=1 and id_in=k), no strobe: clear in_full and in_ovf.
  - Consuming read with in_stb=1 on a full channel: capture the new data; in_full stays 1; in_ovf is cleared, not set.
  - rd on an empty channel: no state change. data_in shows the stale latch value (0 after reset).
- data_in:
  - Purely combinational from id_in and the latch, so the CPU reads in the same cycle it asserts rd.
  - rd only affects the flags.
- Output channel k:
  - Write when we=1 and id_out=k: source = sec ? data_reg : data_mem. out_data[k] loads next edge; out_valid[k] becomes 1.
  - A CPU write always overwrites the holding register, even while valid. The CPU polls out_valid to avoid loss.
  - OUT_HS=1: out_ack[k]=1 while out_valid[k]=1 clears out_valid at the edge. Ack with valid=0 is ignored. Same-cycle write and ack: the write wins and valid stays 1 with the new data.
  - OUT_HS=0: out_valid[k] is 1 for exactly the cycle after each write.
  - out_data holds its value after ack until the next write.
- Channel ids index modulo NCH; no illegal id exists because NCH is a power of two.
- Reads and writes to different channels in the same cycle are independent.

Decomposition:
- Package e_s_pkg:
  - constants SRC_MEM=0, SRC_REG=1;
  - function chan_slice(k) returning the packed bit offset.
- Sub-module e_s_canal_in (one input channel):
  - latch plus full/ovf flags, with ports clk, reset, stb, din, consume, dout, full, ovf;
  - generate-instantiated NCH times.
- Output holding registers and the handshake stay inline in a generate loop.

Test Plan:
- Reset: assert reset 2 cycles with in_stb=all ones -> in_full=0, in_ovf=0, out_valid=0, out_data=0, data_in=0.
- Capture/read: in_stb[2] with in_data[2]=8'hA5 -> next cycle in_full[2]=1 and data_in=A5 with id_in=2. rd=1 -> in_full[2]=0, data_in stays A5.
- Overrun: strobe ch1 with 8'h11, then 8'h22 while full -> data_in=11, in_ovf[1]=1. rd with a simultaneous strobe of 8'h33 -> latch=33, in_full=1, in_ovf=0.
- Output handshake (OUT_HS=1): we, id_out=3, sec=1, data_reg=8'h5C -> out_data[3]=5C, out_valid[3]=1 until out_ack[3]. Ack on the same cycle as a write of 8'h77 -> valid stays 1, data 77.
- Source select: sec=0, data_mem=8'hF0 written to ch0 -> out_data[0]=F0; other channels unchanged.
- OUT_HS=0 build: a single write -> out_valid exactly one cycle high; out_ack ignored; NCH=8, WIDTH=16 build passes the capture/read scenario on ch7.
